// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over valid/ready.
// Optional macro KEY_STORE_EN adds an 11-entry round-key store with rd_round/rd_key.
`timescale 1ns/1ps

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so index from the MSB end.
    logic [10:0] w_idx;
    assign w_idx  = {~i_byte, 3'b000};
    assign o_byte = SBOX[w_idx +: 8];
endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         done
`ifdef KEY_STORE_EN
    ,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
`endif
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_key;
    logic [3:0]     r_round;
    logic           r_done;
    logic           w_xfer;
    logic           w_load;
    logic           w_adv;
    logic           w_fin;
    logic [3:0]     w_rnd_inc;
    logic [7:0]     w_rcon;
    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_rot, w_sub, w_t;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic [127:0]   w_key_nxt;

    assign rk_valid = (r_state == S_EMIT);
    assign busy     = (r_state == S_EMIT);
    assign rk_round = r_round;
    assign rk_out   = r_key;
    assign done     = r_done;
    assign w_xfer   = rk_valid & rk_ready;

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    aes_sbox u_sb0 (.i_byte(w_rot[31:24]), .o_byte(w_sub[31:24]));
    aes_sbox u_sb1 (.i_byte(w_rot[23:16]), .o_byte(w_sub[23:16]));
    aes_sbox u_sb2 (.i_byte(w_rot[15:8]),  .o_byte(w_sub[15:8]));
    aes_sbox u_sb3 (.i_byte(w_rot[7:0]),   .o_byte(w_sub[7:0]));

    assign w_rnd_inc = r_round + 4'd1;

    // Round constant for the key being produced (round index + 1).
    always_comb begin
        w_rcon = 8'h00;
        case (w_rnd_inc)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_t       = w_sub ^ {w_rcon, 24'h0};
    assign w_n0      = w_w0 ^ w_t;
    assign w_n1      = w_w1 ^ w_n0;
    assign w_n2      = w_w2 ^ w_n1;
    assign w_n3      = w_w3 ^ w_n2;
    assign w_key_nxt = {w_n0, w_n1, w_n2, w_n3};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus load/advance/finish strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_fin       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_EMIT;
                    w_load      = 1'b1;
                end
            end
            S_EMIT: begin
                if (w_xfer) begin
                    if (r_round == 4'd10) begin
                        w_state_nxt = S_IDLE;
                        w_fin       = 1'b1;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Round-key datapath; holds on stall and after the last round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key   <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_load) begin
                r_key   <= key_in;
                r_round <= 4'd0;
            end else if (w_adv) begin
                r_key   <= w_key_nxt;
                r_round <= w_rnd_inc;
            end
        end
    end

`ifdef KEY_STORE_EN
    logic [127:0] r_store [11];

    // Capture each round key as it is accepted downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_xfer) begin
            r_store[r_round] <= r_key;
        end
    end

    assign rd_key = (rd_round <= 4'd10) ? r_store[rd_round] : '0;
`endif
endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

- Iterative AES-128 key schedule.
- Accepts a 128-bit cipher key and emits round keys 0..10 in order, one per accepted transfer, over a valid/ready handshake.
- Sits beside the byte-substitution stage. It computes SubWord(RotWord(w3)) with four SBox instances and feeds the round-key input of the AddRoundKey stage.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin expansion of key_in; sampled only when busy=0
- key_in  in  128  cipher key; byte 0 is key_in[127:120]
- busy  out  1  expansion in progress, from the accepted start until round 10 is accepted
- rk_valid  out  1  rk_out/rk_round hold a valid round key
- rk_ready  in  1  downstream accepts the current round key
- rk_round  out  4  index of the round key on rk_out, 0..10
- rk_out  out  128  current round key, words w[4r]..w[4r+3], MSB first
- done  out  1  one-cycle pulse after round 10 is accepted

## Operation
- Words: w0=rk[127:96], w1=rk[95:64], w2=rk[63:32], w3=rk[31:0].
- Next key:
  - t = SubWord({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
- Rcon for producing round r (1..10): 01,02,04,08,10,20,40,80,1b,36. Rcon is selected from rk_round+1 by a 10-entry case. No shifting multiplier.
- SubWord is four SBox instances on the rotated bytes. They are combinational from the rk_out register.
- States:
  - IDLE --start--> EMIT. Latches key_in into rk_out and sets rk_round=0.
  - EMIT, transfer (rk_valid&rk_ready) with rk_round<10: rk_out <= next key, rk_round <= rk_round+1, stay in EMIT.
  - EMIT, transfer with rk_round==10: go to IDLE, pulse done.
  - EMIT, no transfer: hold rk_out, rk_round and rk_valid unchanged. This is a stall.
- rk_valid=1 exactly in EMIT. busy=1 exactly in EMIT.
- start while busy=1 is ignored; no restart and no error.
- rk_round never exceeds 10 and does not wrap.
- Reset mid-expansion: immediately IDLE, all outputs to reset values, in-flight key discarded.

## Timing
- Reset values: busy=0, rk_valid=0, rk_round=0, rk_out=0, done=0. Internal state is IDLE.
- start high at edge T (IDLE): at T+1 rk_valid=1, rk_round=0, rk_out=key_in as sampled at T.
- With rk_ready held high, rounds 0..10 appear on 11 consecutive cycles T+1..T+11.
- After round 10 is accepted at T+11:
  - done=1 during T+12 only.
  - busy=0 and rk_valid=0 from T+12.
- start at T+12 is accepted, so back-to-back keys have a one-cycle gap.
- All outputs are registered except rk_valid/busy, which decode the state register. The SBox path is the critical path: rk_out to next rk_out within one cycle.

## Configuration
- KEY_STORE_EN defined:
  - Adds a register file holding all 11 round keys, written as each key is accepted.
  - Adds ports rd_round in 4 and rd_key out 128. rd_key is a combinational read.
  - rd_round>10 reads 0.
  - Contents are cleared by rst and persist in IDLE until the next start overwrites entries as they are accepted.
  - Serves reverse-order access for the decryption datapath.
- KEY_STORE_EN undefined: no register file, no rd_round/rd_key ports, identical handshake behaviour.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - round 0 = key
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 2 = f2c295f27a96b9435935807a7359f67f
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done pulses at T+12
- All-zero key: round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Random rk_ready stalls: rk_out/rk_round stable while rk_ready=0; the same 11 keys appear in order; done count = 1.
- start pulsed during EMIT with a different key_in: ignored, sequence unchanged. A start in the cycle after done begins the new key's round 0.
- rst asserted while rk_round=5: outputs read 0 immediately (asynchronous). A subsequent start restarts from round 0.
- KEY_STORE_EN: after a full FIPS-197 expansion, rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6 and rd_round=15 gives 0.
